// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The checksum variant is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         WORD_W    = 32;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian 4-lane byte assembler; the finished word is held until the next one completes.
module imem_loader_byte_to_word
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    output logic              lane_last_o
);

    logic [1:0]        lane_q;
    logic [23:0]       acc_q;
    logic [WORD_W-1:0] word_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q  <= 2'd0;
            acc_q   <= 24'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                lane_q <= 2'd0;
            end else if (load_i) begin
                lane_q <= lane_q + 2'd1;
                case (lane_q)
                    2'd0: acc_q[7:0]   <= byte_i;
                    2'd1: acc_q[15:8]  <= byte_i;
                    2'd2: acc_q[23:16] <= byte_i;
                    default: begin
                        word_q  <= {byte_i, acc_q};
                        valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign lane_last_o  = (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 32-bit words into instruction RAM; holds the core in
// reset until a full image lands. Define IMEM_LOADER_CHECKSUM_EN for the trailing sum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH = 64,
    localparam int        AW    = $clog2(DEPTH),
    parameter logic [7:0] SYNC  = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e        state_q, state_d;
    logic          in_ready_q;
    logic [7:0]    cnt_lo_q;
    logic [15:0]   count_q;
    logic [15:0]   count_d;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] waddr_q;
    logic          hs;
    logic          lane_last;
    logic          last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    assign hs        = in_valid && in_ready_q;
    assign count_d   = {in_data, cnt_lo_q};
    assign last_word = ({{(16-AW){1'b0}}, idx_q} == (count_q - 16'd1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (hs && in_data == SYNC) state_d = CNT_LO;
            CNT_LO: if (hs) state_d = CNT_HI;
            CNT_HI: begin
                if (hs) begin
                    if (count_d > 16'(DEPTH))  state_d = ERROR;
                    else if (count_d == 16'd0) state_d = AFTER_DATA;
                    else                       state_d = DATA;
                end
            end
            DATA: if (hs && lane_last && last_word) state_d = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (hs) state_d = (in_data == sum_q) ? DONE : ERROR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            cnt_lo_q   <= 8'd0;
            count_q    <= 16'd0;
            idx_q      <= '0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= 1'b1;
            if (hs) begin
                case (state_q)
                    CNT_LO: cnt_lo_q <= in_data;
                    CNT_HI: begin
                        count_q <= count_d;
                        idx_q   <= '0;
                    end
                    DATA: begin
                        if (lane_last) begin
                            waddr_q <= idx_q;
                            idx_q   <= idx_q + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Sum restarts on every accepted SYNC so a retried frame is checked from scratch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= 8'd0;
        end else if (hs) begin
            if ((state_q == IDLE || state_q == DONE || state_q == ERROR) && in_data == SYNC)
                sum_q <= 8'd0;
            else if (state_q == DATA)
                sum_q <= sum_q + in_data;
        end
    end
`endif

    imem_loader_byte_to_word u_b2w (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (hs && state_q == CNT_HI),
        .load_i       (hs && state_q == DATA),
        .byte_i       (in_data),
        .word_o       (wdata),
        .word_valid_o (we),
        .lane_last_o  (lane_last)
    );

    assign in_ready  = in_ready_q;
    assign waddr     = waddr_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign cpu_reset = (state_q != DONE);
    assign busy      = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                       (state_q == DATA)   || (state_q == CSUM);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, we, cpu_reset, busy, done, error;
    logic [5:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    logic [5:0]  wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          wr_cnt = 0;

    imem_loader dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && wr_cnt < 128) begin
            wr_addr[wr_cnt] = waddr;
            wr_data[wr_cnt] = wdata;
        end
        if (we) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick(1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick(2);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = SYNC_BYTE;
        tick(2);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick(1);
    endtask

    int seq_bad;

    initial begin
        // reset state, with a SYNC byte presented during reset
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = SYNC_BYTE;
        tick(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick(1);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // two-word frame
        wr_cnt = 0;
        send(8'hA5);
        chk("f1_busy", busy, 1);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h00); send(8'h00);
        chk("f1_we0", we, 1);
        send(8'h93); send(8'h05); send(8'h10); send(8'h00);
        chk("f1_we1", we, 1);
        idle();
        chk("f1_wr_cnt", wr_cnt, 2);
        chk("f1_addr0", wr_addr[0], 0);
        chk("f1_data0", wr_data[0], 32'h00000513);
        chk("f1_addr1", wr_addr[1], 1);
        chk("f1_data1", wr_data[1], 32'h00100593);
        chk("f1_done", done, 1);
        chk("f1_cpu_reset", cpu_reset, 0);
        chk("f1_busy_end", busy, 0);
        chk("f1_wdata_hold", wdata, 32'h00100593);

        // leading junk discarded, restart from DONE
        wr_cnt = 0;
        send(8'h00); send(8'hFF);
        chk("f2_junk_done", done, 1);
        send(8'hA5);
        chk("f2_restart_done", done, 0);
        chk("f2_restart_cpu_reset", cpu_reset, 1);
        send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle();
        chk("f2_wr_cnt", wr_cnt, 1);
        chk("f2_addr", wr_addr[0], 0);
        chk("f2_data", wr_data[0], 32'hDEADBEEF);
        chk("f2_done", done, 1);

        // SYNC bytes inside the payload are ordinary data
        wr_cnt = 0;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5);
        idle();
        chk("f3_wr_cnt", wr_cnt, 1);
        chk("f3_data", wr_data[0], 32'hA5A5A5A5);
        chk("f3_done", done, 1);

        // count 65 > DEPTH
        wr_cnt = 0;
        send(8'hA5); send(8'h41); send(8'h00);
        idle();
        chk("f4_error", error, 1);
        chk("f4_cpu_reset", cpu_reset, 1);
        chk("f4_busy", busy, 0);
        chk("f4_done", done, 0);
        chk("f4_wr_cnt", wr_cnt, 0);

        // count 0
        send(8'hA5); send(8'h00); send(8'h00);
        idle();
        chk("f5_done", done, 1);
        chk("f5_error", error, 0);
        chk("f5_wr_cnt", wr_cnt, 0);

        // count 64, one byte every cycle
        wr_cnt = 0;
        send(8'hA5); send(8'h40); send(8'h00);
        for (int k = 0; k < 256; k++) send(8'(k));
        chk("f6_last_we", we, 1);
        chk("f6_last_waddr", waddr, 63);
        chk("f6_last_wdata", wdata, 32'hFFFEFDFC);
        chk("f6_done", done, 1);
        in_valid = 1'b0;
        tick(1);
        chk("f6_we_single", we, 0);
        seq_bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (wr_addr[i] !== 6'(i)) seq_bad++;
            if (wr_data[i] !== {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) seq_bad++;
        end
        chk("f6_wr_cnt", wr_cnt, 64);
        chk("f6_seq_bad", seq_bad, 0);

        // reset after 6 data bytes, then a fresh 1-word frame
        wr_cnt = 0;
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        apply_reset();
        chk("f7_busy_after_rst", busy, 0);
        chk("f7_cpu_reset_after_rst", cpu_reset, 1);
        chk("f7_first_word", wr_data[0], 32'h44332211);
        wr_cnt = 0;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        idle();
        chk("f7_wr_cnt", wr_cnt, 1);
        chk("f7_addr", wr_addr[0], 0);
        chk("f7_data", wr_data[0], 32'h12345678);
        chk("f7_done", done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("cs_wait_busy", busy, 1);
        chk("cs_wait_done", done, 0);
        send(8'h0A);
        idle();
        chk("cs_good_done", done, 1);
        chk("cs_good_error", error, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0B);
        idle();
        chk("cs_bad_error", error, 1);
        chk("cs_bad_cpu_reset", cpu_reset, 1);
        chk("cs_bad_done", done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader and write-side counterpart of the read-only instruction memory.
- Accepts a framed byte stream, for example from the UART RX: sync byte, 16-bit word count, little-endian instruction words, optional checksum.
- Issues one 32-bit word write per instruction to the write port of the instruction RAM.
- Holds the core in reset until a complete, valid image is loaded.

Parameters:
- DEPTH, 64: instruction RAM depth in 32-bit words.
- AW, $clog2(DEPTH): word-address width. Derived; not overridden.
- SYNC, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction RAM write enable, one-cycle pulse.
- waddr  out  AW  word address (byte address >> 2).
- wdata  out  32  assembled instruction word.
- cpu_reset  out  1  active-high core reset request.
- busy  out  1  frame in progress.
- done  out  1  image loaded successfully (level).
- error  out  1  frame rejected (level).

Behaviour:
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, cpu_reset=1, busy=0, done=0, error=0, state=IDLE, all counters 0.
  - Reset wins over any byte handshake in the same cycle.
  - Reset mid-frame abandons the frame; words already written stay in the RAM.
- Handshake: a byte is consumed when in_valid and in_ready are both high at a rising edge.
  - in_ready=1 in every state except during reset.
- IDLE: non-SYNC bytes are discarded. SYNC -> CNT_LO; busy=1, cpu_reset=1, done=0, error=0.
- CNT_LO: byte = count[7:0] -> CNT_HI.
- CNT_HI: byte = count[15:8]. Decision:
  - count > DEPTH -> ERROR.
  - count = 0 -> CSUM if CHECKSUM_EN, else DONE.
  - otherwise -> DATA, with word index = 0 and byte lane = 0.
- DATA: bytes fill wdata little-endian, lane 0 = bits [7:0].
  - On the lane-3 byte: the next cycle shows we=1, waddr=word index, wdata=full word.
  - Write latency is exactly 1 cycle after the 4th byte handshake.
  - Word index increments.
  - After the word at index count-1: -> CSUM if CHECKSUM_EN, else DONE.
  - wdata holds its value between writes.
  - Back-to-back bytes every cycle are supported with no stall.
- DONE: done=1, busy=0, cpu_reset=0 from the cycle after the state is entered.
- ERROR: error=1, busy=0, cpu_reset=1.
- DONE and ERROR: a SYNC byte restarts the sequence (-> CNT_LO, cpu_reset=1, done/error clear). Any other byte is discarded.
- SYNC bytes inside CNT/DATA/CSUM are ordinary data, with no resync.
- waddr never exceeds DEPTH-1; guaranteed by the count check.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, modulo 256, covers all data bytes only; sync and count bytes are excluded.
  - One extra byte is expected in CSUM.
  - Equal -> DONE; unequal -> ERROR.
  - Words already written are not rolled back; cpu_reset stays 1.
- Undefined: CSUM state and sum register are absent; the last data word goes directly to DONE.

Decomposition:
- Package imem_loader_pkg:
  - state enum typedef {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR};
  - SYNC_BYTE constant;
  - word-width constant 32.
- Sub-module byte_to_word:
  - 4-lane little-endian assembler with lane counter, load/clear inputs, and word_valid output.
  - Instantiated once.

Test Plan:
- Reset, then A5 02 00 13 05 00 00 93 05 10 00:
  - we pulses at addr 0 with 32'h00000513, then at addr 1 with 32'h00100593.
  - done=1, cpu_reset=0.
- Bytes 00 FF A5 01 00 EF BE AD DE:
  - Leading bytes are ignored.
  - One write, addr 0, 32'hDEADBEEF; done=1.
- A5 41 00 (count 65 > DEPTH 64): error=1, cpu_reset=1, no we pulse.
- Counts 0 and 64, the boundaries:
  - Count 0 gives done with no writes.
  - Count 64 with bytes every cycle gives the last write at addr 63, 1 cycle after the final byte.
- reset_n=0 after 6 data bytes, then a full 1-word frame:
  - The first frame is abandoned.
  - A new write lands at addr 0; done=1.
- IMEM_LOADER_CHECKSUM_EN, A5 01 00 01 02 03 04 then 0A: done=1. Same frame with trailer 0B: error=1, cpu_reset=1.
